// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: six states per instruction, with internal imem/dmem
// that a host loads while the core is idle. Reports registers[OUT_REG] at halt.
module mips_multicycle_core #(
  parameter int DATA_W     = 8,
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 8,
  parameter int OUT_REG    = 4,
  localparam int PC_W      = $clog2(IMEM_DEPTH),
  localparam int DA_W      = $clog2(DMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_imem_we,
  input  logic              ld_dmem_we,
  input  logic [PC_W-1:0]   ld_addr,
  input  logic [31:0]       ld_data,
  input  logic [PC_W:0]     prog_len,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] out,
  output logic [15:0]       retired
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_READ, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  logic [31:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];
  logic [DATA_W-1:0] regs_q [32];

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, npc_q, npc_d, pc_inc;
  logic [PC_W:0]     len_q;
  logic [31:0]       ir_q;
  logic [DATA_W-1:0] a_q, b_q, alu_q, alu_d, mdr_q, out_q;
  logic              errp_q, done_q, err_q;
  logic [15:0]       retired_q;

  logic [5:0]        op, funct;
  logic [4:0]        rs, rt, rd, wr_idx;
  logic [15:0]       imm;
  logic              is_addu, is_subu, is_slt, is_jr, is_addiu, is_beq, is_bne;
  logic              is_lw, is_sw, is_j, is_jal, valid, wr_en, wb_we, idle;
  logic [DATA_W-1:0] simm, wr_val, halt_out;
  logic [PC_W-1:0]   simm_pc;
  logic [DA_W-1:0]   maddr, ld_da;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign funct = ir_q[5:0];
  assign imm   = ir_q[15:0];

  assign is_addu  = (op == 6'd0) && (funct == 6'd33);
  assign is_subu  = (op == 6'd0) && (funct == 6'd35);
  assign is_slt   = (op == 6'd0) && (funct == 6'd42);
  assign is_jr    = (op == 6'd0) && (funct == 6'd8);
  assign is_addiu = (op == 6'd9);
  assign is_beq   = (op == 6'd4);
  assign is_bne   = (op == 6'd5);
  assign is_lw    = (op == 6'd35);
  assign is_sw    = (op == 6'd43);
  assign is_j     = (op == 6'd2);
  assign is_jal   = (op == 6'd3);
  assign valid    = is_addu | is_subu | is_slt | is_jr | is_addiu | is_beq | is_bne
                  | is_lw | is_sw | is_j | is_jal;

  assign wr_en  = is_addu | is_subu | is_slt | is_addiu | is_lw | is_jal;
  assign wr_idx = is_jal ? 5'd31 : ((is_addiu | is_lw) ? rt : rd);
  assign wr_val = is_lw ? mdr_q : alu_q;
  assign wb_we  = (state_q == S_WB) && !errp_q && wr_en && (wr_idx != 5'd0);
  // Last instruction's writeback lands on the same edge as the halt capture.
  assign halt_out = (wb_we && (wr_idx == 5'(OUT_REG))) ? wr_val : regs_q[OUT_REG];

  assign simm    = DATA_W'($signed(imm));
  assign simm_pc = PC_W'($signed(imm));
  assign pc_inc  = pc_q + PC_W'(1);
  assign maddr   = DA_W'(alu_q);
  assign ld_da   = DA_W'(ld_addr);
  assign idle    = (state_q == S_IDLE) || (state_q == S_HALT);

  always_comb begin
    alu_d = a_q + b_q;
    if (is_subu)                       alu_d = a_q - b_q;
    else if (is_slt)                   alu_d = DATA_W'($signed(a_q) < $signed(b_q));
    else if (is_addiu | is_lw | is_sw) alu_d = a_q + simm;
    else if (is_jal)                   alu_d = DATA_W'(pc_inc);

    npc_d = pc_inc;
    if (!valid)                                        npc_d = pc_q;
    else if (is_j | is_jal)                            npc_d = PC_W'(ir_q[25:0]);
    else if (is_jr)                                    npc_d = PC_W'(a_q);
    else if ((is_beq && a_q == b_q) || (is_bne && a_q != b_q)) npc_d = pc_inc + simm_pc;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT: if (start) state_d = (prog_len == '0) ? S_HALT : S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_READ;
      S_READ:   state_d = S_EXEC;
      S_EXEC:   state_d = S_MEM;
      S_MEM:    state_d = S_WB;
      S_WB:     state_d = (errp_q || ({1'b0, npc_q} >= len_q)) ? S_HALT : S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      npc_q     <= '0;
      len_q     <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      out_q     <= '0;
      errp_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      retired_q <= '0;
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE, S_HALT: if (start) begin
          pc_q      <= '0;
          retired_q <= '0;
          err_q     <= 1'b0;
          len_q     <= prog_len;
          done_q    <= (prog_len == '0);
          if (prog_len == '0) out_q <= regs_q[OUT_REG];
        end
        S_FETCH:  ir_q   <= imem[pc_q];
        S_DECODE: errp_q <= !valid;
        S_READ: begin
          a_q <= regs_q[rs];
          b_q <= regs_q[rt];
        end
        S_EXEC: begin
          alu_q <= alu_d;
          npc_q <= npc_d;
        end
        S_MEM: if (is_lw) mdr_q <= dmem[maddr];
        S_WB: begin
          if (!errp_q) begin
            pc_q <= npc_q;
            if (retired_q != '1) retired_q <= retired_q + 16'd1;
          end
          if (wb_we) regs_q[wr_idx] <= wr_val;
          if (state_d == S_HALT) begin
            done_q <= 1'b1;
            err_q  <= errp_q;
            out_q  <= halt_out;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (idle && ld_imem_we) imem[ld_addr] <= ld_data;
    if (idle && ld_dmem_we) dmem[ld_da] <= ld_data[DATA_W-1:0];
    else if ((state_q == S_MEM) && is_sw && !errp_q) dmem[maddr] <= b_q;
  end

  assign busy    = !idle;
  assign done    = done_q;
  assign err     = err_q;
  assign out     = out_q;
  assign retired = retired_q;
endmodule
